mem_stage_sram_ctrl: RTL and testbench

- Memory (MEM) stage of the 5-stage ARM pipeline; sits directly downstream of the EXE/MEM pipeline register and feeds the MEM/WB register.
- Performs LDR/STR through a multi-cycle controller to an external 16-bit-wide SRAM; each 32-bit word is moved as two half-word accesses.
- Drives `ready`; the hazard/pipeline control uses `~ready` as the global freeze.
- Passes writeback control and the ALU result through unchanged.

---
 rtl/mem_stage_sram_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM pipeline stage with a multi-cycle 16-bit SRAM controller
// Each 32-bit word moves as two half-word accesses; ~ready freezes the pipeline.
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       val_rm_in,
  input  logic [3:0]        dest_in,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [31:0]       alu_result,
  output logic [3:0]        dest,
  output logic [31:0]       mem_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               req, wr, rd, last;
  logic [31:0]        eff_addr;
  logic [ADDR_W-1:0]  lo_addr, hi_addr;

  assign wb_en      = wb_en_in;
  assign mem_r_en   = mem_r_en_in;
  assign alu_result = alu_result_in;
  assign dest       = dest_in;

  // Write wins when both enables are set.
  assign req  = mem_r_en_in | mem_w_en_in;
  assign wr   = mem_w_en_in;
  assign rd   = mem_r_en_in & ~mem_w_en_in;
  assign last = (cnt == CNT_W'(WAIT_CYCLES - 1));

  assign eff_addr = alu_result_in - 32'(BASE_ADDR);
  assign lo_addr  = {eff_addr[ADDR_W:2], 1'b0};
  assign hi_addr  = {eff_addr[ADDR_W:2], 1'b1};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        cnt_nxt = cnt + 1'b1;
        if (last) begin
          cnt_nxt   = '0;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        cnt_nxt = cnt + 1'b1;
        if (last) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM pins are loaded from the next state so they are stable for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_data    <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      case (state_nxt)
        LOW: begin
          sram_addr  <= lo_addr;
          sram_dq_oe <= wr;
          sram_we_n  <= ~wr;
          if (wr) sram_dq_out <= val_rm_in[15:0];
        end
        HIGH: begin
          sram_addr  <= hi_addr;
          sram_dq_oe <= wr;
          sram_we_n  <= ~wr;
          if (wr) sram_dq_out <= val_rm_in[31:16];
        end
        default: begin
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
        end
      endcase
      if (rd && last && state == LOW)  mem_data[15:0]  <= sram_dq_in;
      if (rd && last && state == HIGH) mem_data[31:16] <= sram_dq_in;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - table-driven bench for mem_stage_sram_ctrl with a model SRAM
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_result_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        wb_en, mem_r_en;
  logic [31:0] alu_result, mem_data;
  logic [3:0]  dest;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int checks = 0;
  int errors = 0;

  mem_stage_sram_ctrl dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_result_in(alu_result_in), .val_rm_in(val_rm_in),
    .dest_in(dest_in), .wb_en(wb_en), .mem_r_en(mem_r_en), .alu_result(alu_result),
    .dest(dest), .mem_data(mem_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  logic [15:0] sram_mem [0:262143];
  assign sram_dq_in = sram_mem[sram_addr];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] val;
    logic [17:0] lo;
    logic [17:0] hi;
    logic [31:0] md;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    int b2b;
    vecs[0]  = '{1'b0, 1'b1, 32'd1028,      32'hDEADBEEF, 18'd2,       18'd3,       32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'd1028,      32'h0,        18'd2,       18'd3,       32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b0, 32'h1234,      32'h0,        18'd0,       18'd0,       32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b1, 32'd1024,      32'h55AA1234, 18'd0,       18'd1,       32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b0, 32'd1024,      32'h0,        18'd0,       18'd1,       32'h55AA1234};
    vecs[5]  = '{1'b0, 1'b1, 32'd1040,      32'h01234567, 18'd8,       18'd9,       32'h55AA1234};
    vecs[6]  = '{1'b1, 1'b0, 32'd1043,      32'h0,        18'd8,       18'd9,       32'h01234567};
    vecs[7]  = '{1'b1, 1'b0, 32'd1028,      32'h0,        18'd2,       18'd3,       32'hDEADBEEF};
    vecs[8]  = '{1'b0, 1'b1, 32'd0,         32'h0BADCAFE, 18'h3FE00,   18'h3FE01,   32'hDEADBEEF};
    vecs[9]  = '{1'b1, 1'b0, 32'd0,         32'h0,        18'h3FE00,   18'h3FE01,   32'h0BADCAFE};
    vecs[10] = '{1'b0, 1'b0, 32'hFFFF_0000, 32'h0,        18'd0,       18'd0,       32'h0BADCAFE};

    rst = 1'b1; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    alu_result_in = '0; val_rm_in = '0; dest_in = '0;
    @(negedge clk);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    b2b = 0;
    for (int v = 0; v < 11; v++) begin
      int  ncyc;
      bit  mem, got;
      mem = vecs[v].rd | vecs[v].wr;
      mem_r_en_in = vecs[v].rd; mem_w_en_in = vecs[v].wr;
      alu_result_in = vecs[v].alu; val_rm_in = vecs[v].val;
      wb_en_in = v[0]; dest_in = 4'(v);
      got = 1'b0; ncyc = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        ncyc = c + 1;
        chk($sformatf("v%0d_c%0d_alu_pass", v, c), alu_result, vecs[v].alu);
        chk($sformatf("v%0d_c%0d_dest_pass", v, c), 32'(dest), 32'(v));
        chk($sformatf("v%0d_c%0d_wb_pass", v, c), 32'(wb_en), 32'(v[0]));
        chk($sformatf("v%0d_c%0d_ren_pass", v, c), 32'(mem_r_en), 32'(vecs[v].rd));
        if (mem && c >= 1 && c <= 4) begin
          chk($sformatf("v%0d_c%0d_addr", v, c), 32'(sram_addr), 32'((c <= 2) ? vecs[v].lo : vecs[v].hi));
          chk($sformatf("v%0d_c%0d_we_n", v, c), 32'(sram_we_n), 32'(!vecs[v].wr));
          chk($sformatf("v%0d_c%0d_oe", v, c), 32'(sram_dq_oe), 32'(vecs[v].wr));
          if (vecs[v].wr)
            chk($sformatf("v%0d_c%0d_dq_out", v, c), 32'(sram_dq_out),
                32'((c <= 2) ? vecs[v].val[15:0] : vecs[v].val[31:16]));
        end else begin
          chk($sformatf("v%0d_c%0d_we_n", v, c), 32'(sram_we_n), 32'd1);
          chk($sformatf("v%0d_c%0d_oe", v, c), 32'(sram_dq_oe), 32'd0);
        end
        chk($sformatf("v%0d_c%0d_ready", v, c), 32'(ready), (!mem || c == 5) ? 32'd1 : 32'd0);
        if (ready) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) chk($sformatf("v%0d_ready_timeout", v), 32'd0, 32'd1);
      chk($sformatf("v%0d_cycles", v), 32'(ncyc), mem ? 32'd6 : 32'd1);
      chk($sformatf("v%0d_mem_data", v), mem_data, vecs[v].md);
      if (v <= 1) b2b += ncyc;
      if (v == 1) chk("b2b_total_cycles", 32'(b2b), 32'd12);
      @(posedge clk); #1;
    end

    mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
    alu_result_in = 32'd1028; val_rm_in = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    chk("midlow_we_n", 32'(sram_we_n), 32'd0);
    chk("midlow_addr", 32'(sram_addr), 32'd2);
    #1;
    rst = 1'b1; mem_w_en_in = 1'b0;
    #1;
    chk("arst_we_n", 32'(sram_we_n), 32'd1);
    chk("arst_oe", 32'(sram_dq_oe), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_mem_data", mem_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_we_n", 32'(sram_we_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
